// File: rtl/omsp_sram_arb_if.sv
// rtl/omsp_sram_arb_if.sv - one master's request/response port into the SRAM arbiter
interface omsp_sram_arb_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  req;
    logic [1:0]            wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           din;
    logic                  lock;
    logic                  gnt;
    logic                  rvalid;
    logic [15:0]           rdata;

    modport master (
        output req, wen, addr, din, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wen, addr, din, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/omsp_sram_arb.sv
// rtl/omsp_sram_arb.sv - two-master round-robin/lock arbiter in front of the SRAM controller core port
module omsp_sram_arb #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    omsp_sram_arb_if.slave        m0,
    omsp_sram_arb_if.slave        m1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cen,
    output logic [1:0]            ram_wen,
    output logic [15:0]           ram_din,
    input  logic [15:0]           ram_dout
);

    logic                  r_last_gnt;
    logic                  r_locked;
    logic                  r_lock_owner;
    logic [1:0]            r_rd_pend;
    logic [ADDR_WIDTH-1:0] r_addr_sh;
    logic [15:0]           r_din_sh;
    logic [15:0]           r_rdata0;
    logic [15:0]           r_rdata1;

    logic                  w_hold;
    logic                  w_any;
    logic                  w_win;
    logic [1:0]            w_win_wen;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [15:0]           w_win_din;
    logic                  w_win_lock;
    logic                  w_win_rd;

    // The lock only holds while its owner keeps requesting; an idle owner releases it.
    assign w_hold = r_locked & (r_lock_owner ? m1.req : m0.req);

    // Winner selection: lock owner first, then a lone requester, then round-robin.
    always_comb begin
        w_any = 1'b0;
        w_win = 1'b0;
        if (rst_n) begin
            if (w_hold) begin
                w_any = 1'b1;
                w_win = r_lock_owner;
            end else if (m0.req && m1.req) begin
                w_any = 1'b1;
                w_win = ~r_last_gnt;
            end else if (m0.req) begin
                w_any = 1'b1;
                w_win = 1'b0;
            end else if (m1.req) begin
                w_any = 1'b1;
                w_win = 1'b1;
            end
        end
    end

    assign w_win_wen  = w_win ? m1.wen  : m0.wen;
    assign w_win_addr = w_win ? m1.addr : m0.addr;
    assign w_win_din  = w_win ? m1.din  : m0.din;
    assign w_win_lock = w_win ? m1.lock : m0.lock;
    assign w_win_rd   = (w_win_wen == 2'b11);

    assign m0.gnt = w_any & ~w_win;
    assign m1.gnt = w_any &  w_win;

    // Winner drives the SRAM port in the same cycle; idle cycles park addr/din on the last access.
    assign ram_cen  = ~w_any;
    assign ram_wen  = w_any ? w_win_wen  : 2'b11;
    assign ram_addr = w_any ? w_win_addr : r_addr_sh;
    assign ram_din  = w_any ? w_win_din  : r_din_sh;

    // Read data arrives one cycle after issue and is steered by the pending bit of the issuer.
    assign m0.rvalid = r_rd_pend[0];
    assign m1.rvalid = r_rd_pend[1];
    assign m0.rdata  = r_rd_pend[0] ? ram_dout : r_rdata0;
    assign m1.rdata  = r_rd_pend[1] ? ram_dout : r_rdata1;

    // Arbitration history, lock tracking, port shadows and read-return bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt   <= 1'b1;
            r_locked     <= 1'b0;
            r_lock_owner <= 1'b0;
            r_rd_pend    <= 2'b00;
            r_addr_sh    <= '0;
            r_din_sh     <= 16'h0000;
            r_rdata0     <= 16'h0000;
            r_rdata1     <= 16'h0000;
        end else begin
            if (w_any) begin
                r_last_gnt   <= w_win;
                r_locked     <= w_win_lock;
                r_lock_owner <= w_win;
                r_addr_sh    <= w_win_addr;
                r_din_sh     <= w_win_din;
            end else begin
                r_locked     <= 1'b0;
            end
            r_rd_pend <= {w_any & w_win & w_win_rd, w_any & ~w_win & w_win_rd};
            if (r_rd_pend[0]) begin
                r_rdata0 <= ram_dout;
            end
            if (r_rd_pend[1]) begin
                r_rdata1 <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_omsp_sram_arb.sv
// tb/tb_omsp_sram_arb.sv - vector-table bench for omsp_sram_arb with a behavioural SRAM
module tb_omsp_sram_arb;

    localparam int AW = 9;
    localparam logic [1:0] RD = 2'b11;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_addr;
    logic          ram_cen;
    logic [1:0]    ram_wen;
    logic [15:0]   ram_din;
    logic [15:0]   ram_dout;
    logic          mem_init;
    logic [15:0]   mem [0:511];

    int n_chk  = 0;
    int n_pass = 0;

    omsp_sram_arb_if #(.ADDR_WIDTH(AW)) m0_if ();
    omsp_sram_arb_if #(.ADDR_WIDTH(AW)) m1_if ();

    omsp_sram_arb #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_addr (ram_addr),
        .ram_cen  (ram_cen),
        .ram_wen  (ram_wen),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle SRAM: read data registered, active-low byte write enables.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'hB000 ^ 16'(i);
        end else if (!ram_cen) begin
            if (ram_wen == 2'b11) begin
                ram_dout <= mem[ram_addr];
            end else begin
                if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
                if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            end
        end
    end

    typedef struct {
        logic          rst;
        logic          r0;  logic [1:0] w0; logic [AW-1:0] a0; logic [15:0] d0; logic l0;
        logic          r1;  logic [1:0] w1; logic [AW-1:0] a1; logic [15:0] d1; logic l1;
        logic          g0;  logic g1; logic v0; logic v1;
        logic [15:0]   ed0; logic [15:0] ed1; logic cd;
        logic          cen; logic [1:0] wen; logic [AW-1:0] eaddr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst,
        input logic r0, input logic [1:0] w0, input logic [AW-1:0] a0, input logic [15:0] d0, input logic l0,
        input logic r1, input logic [1:0] w1, input logic [AW-1:0] a1, input logic [15:0] d1, input logic l1,
        input logic g0, input logic g1, input logic v0, input logic v1,
        input logic [15:0] ed0, input logic [15:0] ed1, input logic cd,
        input logic cen, input logic [1:0] wen, input logic [AW-1:0] eaddr);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.ed0 = ed0; v.ed1 = ed1; v.cd = cd;
        v.cen = cen; v.wen = wen; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rst,
        input logic r0, input logic [1:0] w0, input logic [AW-1:0] a0, input logic [15:0] d0, input logic l0,
        input logic r1, input logic [1:0] w1, input logic [AW-1:0] a1, input logic [15:0] d1, input logic l1);
        @(negedge clk);
        rst_n = rst;
        m0_if.req = r0; m0_if.wen = w0; m0_if.addr = a0; m0_if.din = d0; m0_if.lock = l0;
        m1_if.req = r1; m1_if.wen = w1; m1_if.addr = a1; m1_if.din = d1; m1_if.lock = l1;
        #4;
    endtask

    task automatic apply(input int idx, input vec_t v);
        drive(v.rst, v.r0, v.w0, v.a0, v.d0, v.l0, v.r1, v.w1, v.a1, v.d1, v.l1);
        chk($sformatf("v%0d m0_gnt", idx),    32'(m0_if.gnt),    32'(v.g0));
        chk($sformatf("v%0d m1_gnt", idx),    32'(m1_if.gnt),    32'(v.g1));
        chk($sformatf("v%0d m0_rvalid", idx), 32'(m0_if.rvalid), 32'(v.v0));
        chk($sformatf("v%0d m1_rvalid", idx), 32'(m1_if.rvalid), 32'(v.v1));
        chk($sformatf("v%0d ram_cen", idx),   32'(ram_cen),      32'(v.cen));
        chk($sformatf("v%0d ram_wen", idx),   32'(ram_wen),      32'(v.wen));
        chk($sformatf("v%0d ram_addr", idx),  32'(ram_addr),     32'(v.eaddr));
        if (v.cd || v.v0) chk($sformatf("v%0d m0_rdata", idx), 32'(m0_if.rdata), 32'(v.ed0));
        if (v.cd || v.v1) chk($sformatf("v%0d m1_rdata", idx), 32'(m1_if.rdata), 32'(v.ed1));
    endtask

    initial begin
        rst_n = 1'b0;
        mem_init = 1'b1;
        m0_if.req = 1'b0; m0_if.wen = RD; m0_if.addr = '0; m0_if.din = '0; m0_if.lock = 1'b0;
        m1_if.req = 1'b0; m1_if.wen = RD; m1_if.addr = '0; m1_if.din = '0; m1_if.lock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;

        // reset: grants forced low even with requests present
        vq.push_back(mk(0, 1,RD,9'h005,16'h0,0, 1,RD,9'h006,16'h0,0, 0,0,0,0, 16'h0,16'h0,1, 1,RD,9'h000));
        vq.push_back(mk(0, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,0,0, 16'h0,16'h0,1, 1,RD,9'h000));
        // m0 alone: write then read back
        vq.push_back(mk(1, 1,2'b00,9'h005,16'hA55A,0, 0,RD,9'h000,16'h0,0, 1,0,0,0, 16'h0,16'h0,0, 0,2'b00,9'h005));
        vq.push_back(mk(1, 1,RD,9'h005,16'h0,0, 0,RD,9'h000,16'h0,0, 1,0,0,0, 16'h0,16'h0,0, 0,RD,9'h005));
        vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,1,0, 16'hA55A,16'h0,1, 1,RD,9'h005));
        // re-reset, then both masters read continuously
        vq.push_back(mk(0, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,0,0, 16'hA55A,16'h0,1, 1,RD,9'h005));
        vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,RD,9'h030,16'h0,0, 1,0,0,0, 16'h0,16'h0,1, 0,RD,9'h020));
        vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,RD,9'h030,16'h0,0, 0,1,1,0, 16'hB020,16'h0,1, 0,RD,9'h030));
        vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,RD,9'h030,16'h0,0, 1,0,0,1, 16'hB020,16'hB030,1, 0,RD,9'h020));
        vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,RD,9'h030,16'h0,0, 0,1,1,0, 16'hB020,16'hB030,1, 0,RD,9'h030));
        vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,0,1, 16'hB020,16'hB030,1, 1,RD,9'h030));
        // m1 locked write burst against a competing m0 read
        vq.push_back(mk(1, 1,2'b00,9'h040,16'h1111,0, 0,RD,9'h000,16'h0,0, 1,0,0,0, 16'h0,16'h0,0, 0,2'b00,9'h040));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,2'b00,9'h010,16'hBEEF,1, 0,1,0,0, 16'h0,16'h0,0, 0,2'b00,9'h010));
        vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,2'b00,9'h010,16'hBEEF,0, 0,1,0,0, 16'h0,16'h0,0, 0,2'b00,9'h010));
        vq.push_back(mk(1, 1,RD,9'h020,16'h0,0, 1,2'b00,9'h010,16'hBEEF,0, 1,0,0,0, 16'h0,16'h0,0, 0,RD,9'h020));
        vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,1,0, 16'hB020,16'hB030,1, 1,RD,9'h020));
        // byte write: full word, then high byte only, then read
        vq.push_back(mk(1, 1,2'b00,9'h050,16'h1234,0, 0,RD,9'h000,16'h0,0, 1,0,0,0, 16'h0,16'h0,0, 0,2'b00,9'h050));
        vq.push_back(mk(1, 1,2'b01,9'h050,16'hFF00,0, 0,RD,9'h000,16'h0,0, 1,0,0,0, 16'h0,16'h0,0, 0,2'b01,9'h050));
        vq.push_back(mk(1, 1,RD,9'h050,16'h0,0, 0,RD,9'h000,16'h0,0, 1,0,0,0, 16'h0,16'h0,0, 0,RD,9'h050));
        vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,1,0, 16'hFF34,16'hB030,1, 1,RD,9'h050));
        // reset while m1 holds the lock with a read in flight
        vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 1,RD,9'h010,16'h0,1, 0,1,0,0, 16'h0,16'h0,0, 0,RD,9'h010));
        vq.push_back(mk(0, 1,RD,9'h050,16'h0,0, 1,RD,9'h010,16'h0,1, 0,0,0,1, 16'hFF34,16'hBEEF,1, 1,RD,9'h010));
        vq.push_back(mk(1, 1,RD,9'h050,16'h0,0, 1,RD,9'h010,16'h0,1, 1,0,0,0, 16'h0,16'h0,1, 0,RD,9'h050));
        vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,1,0, 16'hFF34,16'h0,1, 1,RD,9'h050));
        // ten idle cycles: port parked, read data held
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0, 0,0,0,0, 16'hFF34,16'h0,1, 1,RD,9'h050));

        foreach (vq[i]) apply(i, vq[i]);

        // lock released when its owner goes idle, then round-robin resumes
        drive(1, 1,RD,9'h020,16'h0,1, 0,RD,9'h000,16'h0,0);
        chk("seq m0 locked gnt", 32'(m0_if.gnt), 32'd1);
        drive(1, 0,RD,9'h000,16'h0,0, 1,RD,9'h030,16'h0,0);
        chk("seq owner idle m1_gnt", 32'(m1_if.gnt), 32'd1);
        chk("seq owner idle m0_gnt", 32'(m0_if.gnt), 32'd0);
        chk("seq m0_rvalid", 32'(m0_if.rvalid), 32'd1);
        chk("seq m0_rdata", 32'(m0_if.rdata), 32'hB020);
        drive(1, 1,RD,9'h020,16'h0,0, 1,RD,9'h030,16'h0,0);
        chk("seq rr m0_gnt", 32'(m0_if.gnt), 32'd1);
        chk("seq rr m1_rvalid", 32'(m1_if.rvalid), 32'd1);
        chk("seq rr m1_rdata", 32'(m1_if.rdata), 32'hB030);
        drive(1, 1,RD,9'h020,16'h0,0, 1,RD,9'h030,16'h0,0);
        chk("seq rr2 m1_gnt", 32'(m1_if.gnt), 32'd1);
        chk("seq rr2 m0_rvalid", 32'(m0_if.rvalid), 32'd1);
        drive(1, 0,RD,9'h000,16'h0,0, 0,RD,9'h000,16'h0,0);
        chk("seq end m1_rvalid", 32'(m1_if.rvalid), 32'd1);
        chk("seq end ram_cen", 32'(ram_cen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
